// File: rtl/hdlc_pkg.sv
// Shared HDLC receive-path types and frame-size constants.
package hdlc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    RECEIVE,
    DONE
  } rx_state_t;

  localparam int FCS_BYTES       = 2;
  localparam int MIN_FRAME_BYTES = 4;
  localparam int RX_BUF_BYTES    = 128;

endpackage

// File: rtl/rx_byte_cnt.sv
// Saturating Rx byte counter; also registers the buffer write address of the byte just counted.
module rx_byte_cnt
  import hdlc_pkg::*;
#(
  parameter int MAX_BYTES = RX_BUF_BYTES,
  parameter int ADDR_W    = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W:0]   cnt_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              full_o
);

  localparam int CW = ADDR_W + 1;
  localparam logic [ADDR_W:0] ONE = CW'(1);

  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign full_o = (cnt_q == CW'(MAX_BYTES));
  assign cnt_o  = cnt_q;
  assign addr_o = addr_q;

  // The address of a write is the count before it is incremented.
  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    if (clr_i) begin
      cnt_d  = '0;
      addr_d = '0;
    end else if (inc_i && !full_o) begin
      addr_d = cnt_q[ADDR_W-1:0];
      cnt_d  = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      addr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// HDLC Rx frame sequencer: opens/closes frames on flags, steers bytes into the Rx buffer,
// and holds a good frame until software reads or drops it.
module rx_frame_ctrl
  import hdlc_pkg::*;
#(
  parameter int MAX_BYTES = RX_BUF_BYTES,
  parameter int ADDR_W    = 7
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              RxEN,
  input  logic              Rx_FlagDetect,
  input  logic              Rx_AbortDetect,
  input  logic              Rx_NewByte,
  input  logic [7:0]        Rx_Data,
  input  logic              Rx_FCSErr,
  input  logic              Rx_ReadDone,
  input  logic              Rx_Drop,
  output logic              Rx_ValidFrame,
  output logic              Rx_AbortSignal,
  output logic              Rx_WrBuff,
  output logic [ADDR_W-1:0] Rx_WrAddr,
  output logic [7:0]        Rx_DataBuffOut,
  output logic [7:0]        Rx_FrameSize,
  output logic              Rx_EoF,
  output logic              Rx_Ready,
  output logic              Rx_Overflow,
  output logic              Rx_FrameError
);

  localparam int CW = ADDR_W + 1;

  rx_state_t   state_q;
  logic        valid_q, abort_q, wr_q, eof_q, ready_q, ovf_q, ferr_q;
  logic [7:0]  data_q, size_q;
  logic [ADDR_W:0] cnt;
  logic        full, cnt_clr, cnt_inc, bad_frame;

  // Abort beats flag beats byte; a byte coinciding with either is dropped.
  always_comb begin
    bad_frame = (cnt < CW'(MIN_FRAME_BYTES)) || Rx_FCSErr;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    if (!RxEN) begin
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        IDLE:    cnt_clr = Rx_FlagDetect;
        START: begin
          cnt_clr = Rx_FlagDetect && !Rx_AbortDetect;
          cnt_inc = Rx_NewByte && !Rx_FlagDetect && !Rx_AbortDetect;
        end
        RECEIVE: begin
          cnt_clr = Rx_FlagDetect && !Rx_AbortDetect && bad_frame;
          cnt_inc = Rx_NewByte && !Rx_FlagDetect && !Rx_AbortDetect && !full;
        end
        DONE:    cnt_clr = Rx_ReadDone || Rx_Drop;
        default: cnt_clr = 1'b1;
      endcase
    end
  end

  rx_byte_cnt #(
    .MAX_BYTES (MAX_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_cnt (
    .clk_i  (Clk),
    .rst_ni (Rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .cnt_o  (cnt),
    .addr_o (Rx_WrAddr),
    .full_o (full)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      wr_q    <= 1'b0;
      eof_q   <= 1'b0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      size_q  <= '0;
    end else begin
      wr_q    <= 1'b0;
      eof_q   <= 1'b0;
      abort_q <= 1'b0;
      if (!RxEN) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        ready_q <= 1'b0;
        ovf_q   <= 1'b0;
        ferr_q  <= 1'b0;
        data_q  <= '0;
        size_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (Rx_FlagDetect) begin
              state_q <= START;
              ovf_q   <= 1'b0;
              ferr_q  <= 1'b0;
            end
          end
          START: begin
            if (Rx_AbortDetect) begin
              state_q <= IDLE;
            end else if (Rx_FlagDetect) begin
              ovf_q  <= 1'b0;
              ferr_q <= 1'b0;
            end else if (Rx_NewByte) begin
              state_q <= RECEIVE;
              valid_q <= 1'b1;
              wr_q    <= 1'b1;
              data_q  <= Rx_Data;
              ovf_q   <= 1'b0;
              ferr_q  <= 1'b0;
            end
          end
          RECEIVE: begin
            if (Rx_AbortDetect) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              abort_q <= 1'b1;
            end else if (Rx_FlagDetect) begin
              valid_q <= 1'b0;
              eof_q   <= 1'b1;
              if (bad_frame) begin
                ferr_q  <= 1'b1;
                ready_q <= 1'b0;
                state_q <= START;
              end else begin
                size_q  <= 8'(cnt) - 8'(FCS_BYTES);
                ready_q <= 1'b1;
                state_q <= DONE;
              end
            end else if (Rx_NewByte) begin
              if (full) begin
                ovf_q <= 1'b1;
              end else begin
                wr_q   <= 1'b1;
                data_q <= Rx_Data;
              end
            end
          end
          DONE: begin
            if (Rx_ReadDone || Rx_Drop) begin
              state_q <= IDLE;
              ready_q <= 1'b0;
              size_q  <= '0;
              ovf_q   <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign Rx_ValidFrame  = valid_q;
  assign Rx_AbortSignal = abort_q;
  assign Rx_WrBuff      = wr_q;
  assign Rx_DataBuffOut = data_q;
  assign Rx_FrameSize   = size_q;
  assign Rx_EoF         = eof_q;
  assign Rx_Ready       = ready_q;
  assign Rx_Overflow    = ovf_q;
  assign Rx_FrameError  = ferr_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl with hand-computed expectations.
module tb_rx_frame_ctrl;

  logic       Clk = 1'b0;
  logic       Rst, RxEN, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte, Rx_FCSErr;
  logic       Rx_ReadDone, Rx_Drop;
  logic [7:0] Rx_Data;
  logic       Rx_ValidFrame, Rx_AbortSignal, Rx_WrBuff, Rx_EoF, Rx_Ready;
  logic       Rx_Overflow, Rx_FrameError;
  logic [6:0] Rx_WrAddr;
  logic [7:0] Rx_DataBuffOut, Rx_FrameSize;

  int n_vec = 0;
  int n_err = 0;
  int wr_seen = 0;
  int last_addr = -1;

  always #5 Clk = ~Clk;

  rx_frame_ctrl dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .RxEN           (RxEN),
    .Rx_FlagDetect  (Rx_FlagDetect),
    .Rx_AbortDetect (Rx_AbortDetect),
    .Rx_NewByte     (Rx_NewByte),
    .Rx_Data        (Rx_Data),
    .Rx_FCSErr      (Rx_FCSErr),
    .Rx_ReadDone    (Rx_ReadDone),
    .Rx_Drop        (Rx_Drop),
    .Rx_ValidFrame  (Rx_ValidFrame),
    .Rx_AbortSignal (Rx_AbortSignal),
    .Rx_WrBuff      (Rx_WrBuff),
    .Rx_WrAddr      (Rx_WrAddr),
    .Rx_DataBuffOut (Rx_DataBuffOut),
    .Rx_FrameSize   (Rx_FrameSize),
    .Rx_EoF         (Rx_EoF),
    .Rx_Ready       (Rx_Ready),
    .Rx_Overflow    (Rx_Overflow),
    .Rx_FrameError  (Rx_FrameError)
  );

  // {ValidFrame, AbortSignal, WrBuff, EoF, Ready, Overflow, FrameError}
  function automatic logic [6:0] ctrl();
    return {Rx_ValidFrame, Rx_AbortSignal, Rx_WrBuff, Rx_EoF, Rx_Ready, Rx_Overflow, Rx_FrameError};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    if (Rx_WrBuff) begin
      wr_seen++;
      last_addr = int'(Rx_WrAddr);
    end
  endtask

  task automatic flag(input logic fcserr);
    Rx_FlagDetect = 1'b1;
    Rx_FCSErr     = fcserr;
    tick();
    Rx_FlagDetect = 1'b0;
    Rx_FCSErr     = 1'b0;
  endtask

  task automatic byte_in(input logic [7:0] d);
    Rx_Data    = d;
    Rx_NewByte = 1'b1;
    tick();
    Rx_NewByte = 1'b0;
  endtask

  task automatic bytes(input int n);
    for (int i = 0; i < n; i++) byte_in(8'(i + 1));
  endtask

  logic [7:0] basic [4];

  initial begin
    basic[0] = 8'hA5; basic[1] = 8'h3C; basic[2] = 8'h11; basic[3] = 8'h22;
    Rst = 1'b0; RxEN = 1'b1; Rx_FlagDetect = 1'b0; Rx_AbortDetect = 1'b0;
    Rx_NewByte = 1'b0; Rx_Data = 8'h00; Rx_FCSErr = 1'b0; Rx_ReadDone = 1'b0; Rx_Drop = 1'b0;

    // Reset state
    #12;
    check("reset_ctrl", 32'(ctrl()), 32'h0);
    check("reset_addr", 32'(Rx_WrAddr), 32'h0);
    check("reset_size", 32'(Rx_FrameSize), 32'h0);
    Rst = 1'b1;
    tick();

    // Basic good frame
    flag(1'b0);
    check("basic_open_valid", 32'(Rx_ValidFrame), 32'h0);
    for (int i = 0; i < 4; i++) begin
      byte_in(basic[i]);
      check("basic_wr", 32'(Rx_WrBuff), 32'h1);
      check("basic_addr", 32'(Rx_WrAddr), 32'(i));
      check("basic_data", 32'(Rx_DataBuffOut), 32'(basic[i]));
      check("basic_valid", 32'(Rx_ValidFrame), 32'h1);
    end
    flag(1'b0);
    check("basic_close_ctrl", 32'(ctrl()), 32'b0001100);
    check("basic_size", 32'(Rx_FrameSize), 32'd2);
    tick();
    check("basic_hold_ctrl", 32'(ctrl()), 32'b0000100);
    Rx_ReadDone = 1'b1; tick(); Rx_ReadDone = 1'b0;
    check("basic_read_ready", 32'(Rx_Ready), 32'h0);
    check("basic_read_size", 32'(Rx_FrameSize), 32'h0);

    // Abort in RECEIVE, then abort in IDLE
    flag(1'b0);
    bytes(3);
    Rx_AbortDetect = 1'b1; tick(); Rx_AbortDetect = 1'b0;
    check("abort_pulse_ctrl", 32'(ctrl()), 32'b0100000);
    tick();
    check("abort_after_ctrl", 32'(ctrl()), 32'b0000000);
    Rx_AbortDetect = 1'b1; tick(); Rx_AbortDetect = 1'b0;
    check("abort_idle_sig", 32'(Rx_AbortSignal), 32'h0);
    byte_in(8'h77);
    check("idle_byte_nowrite", 32'(Rx_WrBuff), 32'h0);

    // Overflow: 130 bytes into a 128-byte buffer
    flag(1'b0);
    wr_seen = 0;
    bytes(130);
    check("ovf_writes", 32'(wr_seen), 32'd128);
    check("ovf_last_addr", 32'(last_addr), 32'd127);
    check("ovf_flag", 32'(Rx_Overflow), 32'h1);
    flag(1'b0);
    check("ovf_close_ctrl", 32'(ctrl()), 32'b0001110);
    check("ovf_size", 32'(Rx_FrameSize), 32'd126);
    Rx_Drop = 1'b1; tick(); Rx_Drop = 1'b0;
    check("ovf_drop_ctrl", 32'(ctrl()), 32'b0000000);

    // FCS error, clearing on the next opening flag, then short frame
    flag(1'b0);
    bytes(4);
    flag(1'b1);
    check("fcs_err_ctrl", 32'(ctrl()), 32'b0001001);
    flag(1'b0);
    check("ferr_cleared", 32'(Rx_FrameError), 32'h0);
    bytes(4);
    flag(1'b0);
    check("good_after_err", 32'(ctrl()), 32'b0001100);
    Rx_ReadDone = 1'b1; tick(); Rx_ReadDone = 1'b0;
    flag(1'b0);
    bytes(3);
    flag(1'b0);
    check("short_err_ctrl", 32'(ctrl()), 32'b0001001);

    // Closing flag reopened START: bytes go straight in, then abort+flag together
    byte_in(8'h55);
    check("reopen_addr", 32'(Rx_WrAddr), 32'h0);
    check("reopen_ctrl", 32'(ctrl()), 32'b1010000);
    bytes(2);
    Rx_AbortDetect = 1'b1; Rx_FlagDetect = 1'b1; tick();
    Rx_AbortDetect = 1'b0; Rx_FlagDetect = 1'b0;
    check("abort_beats_flag", 32'(ctrl()), 32'b0100000);

    // Byte together with closing flag is discarded
    flag(1'b0);
    bytes(4);
    wr_seen = 0;
    Rx_Data = 8'hEE; Rx_NewByte = 1'b1; Rx_FlagDetect = 1'b1; tick();
    Rx_NewByte = 1'b0; Rx_FlagDetect = 1'b0;
    check("flag_beats_byte", 32'(ctrl()), 32'b0001100);
    check("flag_byte_size", 32'(Rx_FrameSize), 32'd2);

    // Traffic during DONE is ignored
    flag(1'b0);
    bytes(5);
    flag(1'b0);
    Rx_AbortDetect = 1'b1; tick(); Rx_AbortDetect = 1'b0;
    check("done_no_writes", 32'(wr_seen), 32'd0);
    check("done_hold_ctrl", 32'(ctrl()), 32'b0000100);
    check("done_hold_size", 32'(Rx_FrameSize), 32'd2);
    Rx_Drop = 1'b1; tick(); Rx_Drop = 1'b0;
    check("done_drop_ready", 32'(Rx_Ready), 32'h0);

    // Asynchronous reset mid-frame
    flag(1'b0);
    bytes(5);
    check("pre_reset_addr", 32'(Rx_WrAddr), 32'd4);
    #2 Rst = 1'b0;
    #1;
    check("async_reset_ctrl", 32'(ctrl()), 32'h0);
    check("async_reset_addr", 32'(Rx_WrAddr), 32'h0);
    check("async_reset_data", 32'(Rx_DataBuffOut), 32'h0);
    Rst = 1'b1;
    tick();

    // Receiver disable mid-frame
    flag(1'b0);
    bytes(5);
    RxEN = 1'b0;
    tick();
    check("disable_ctrl", 32'(ctrl()), 32'h0);
    check("disable_addr", 32'(Rx_WrAddr), 32'h0);
    check("disable_data", 32'(Rx_DataBuffOut), 32'h0);
    wr_seen = 0;
    flag(1'b0);
    bytes(3);
    check("disabled_ignored", 32'(wr_seen), 32'd0);
    check("disabled_valid", 32'(Rx_ValidFrame), 32'h0);
    RxEN = 1'b1;
    byte_in(8'h42);
    check("reenable_idle_nowrite", 32'(Rx_WrBuff), 32'h0);
    flag(1'b0);
    byte_in(8'h42);
    check("reenable_wr", 32'(ctrl()), 32'b1010000);
    check("reenable_addr", 32'(Rx_WrAddr), 32'h0);
    check("reenable_data", 32'(Rx_DataBuffOut), 32'h42);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
